// File: rtl/ysyx_22040729_trap_ctrl.sv
// ysyx_22040729_trap_ctrl
//   Trap/return sequencer sitting at the commit point. When a committing
//   instruction carries a pending interrupt, an ecall or an mret, the
//   controller stalls commit, flushes younger stages, waits for memory to
//   go idle, strobes the CSR file once, then redirects fetch.
//
// State table
//   state      | meaning
//   IDLE       | accepting commits, watching for a trap/mret
//   DRAIN      | flushing, waiting for outstanding memory traffic to finish
//   COMMIT     | one-cycle CSR update strobe, redirect target captured
//   REDIRECT   | presenting redirect_pc_o until fetch accepts it
//
// Ports
//   clk, rst                 clock, async active-high reset
//   cmt_valid_i/pc/ecall/mret  committing instruction
//   cmt_ready_o              high only in IDLE
//   eirp_i, tirp_i           gated external / timer interrupt requests
//   mtvec_i, mepc_i          current CSR values for the redirect target
//   lsu_idle_i               no memory transaction in flight
//   csr_exception_o/mret_o   one-cycle CSR hardware-update strobes
//   csr_mepc/mcause_hwdata_o trap values, valid only with csr_exception_o
//   flush_o                  kill younger stages (every state but IDLE)
//   redirect_valid_o/pc_o, redirect_ready_i  fetch redirect handshake
module ysyx_22040729_trap_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmt_valid_i,
  input  logic [DATA_WIDTH-1:0] cmt_pc_i,
  input  logic                  cmt_ecall_i,
  input  logic                  cmt_mret_i,
  output logic                  cmt_ready_o,
  input  logic                  eirp_i,
  input  logic                  tirp_i,
  input  logic [DATA_WIDTH-1:0] mtvec_i,
  input  logic [DATA_WIDTH-1:0] mepc_i,
  input  logic                  lsu_idle_i,
  output logic                  csr_exception_o,
  output logic                  csr_mret_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_hwdata_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_hwdata_o,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  input  logic                  redirect_ready_i
);

  localparam logic [DATA_WIDTH-1:0] CAUSE_EIRP  = {1'b1, (DATA_WIDTH-1)'(11)};
  localparam logic [DATA_WIDTH-1:0] CAUSE_TIRP  = {1'b1, (DATA_WIDTH-1)'(7)};
  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL = DATA_WIDTH'(11);
  // Direct mode only: the low two mode bits of mtvec never reach the PC.
  localparam logic [DATA_WIDTH-1:0] TVEC_MASK   = ~(DATA_WIDTH'(3));

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, cause_q, target_q;
  logic                  mret_q;

  logic                  take;
  logic                  take_mret;
  logic [DATA_WIDTH-1:0] take_cause;
  logic [DATA_WIDTH-1:0] commit_target;

  // Only the highest-priority event is serviced; anything lower in the same
  // cycle is dropped and the instruction replays after the handler.
  always_comb begin
    take       = cmt_valid_i & (eirp_i | tirp_i | cmt_ecall_i | cmt_mret_i);
    take_mret  = 1'b0;
    take_cause = '0;
    if (eirp_i) begin
      take_cause = CAUSE_EIRP;
    end else if (tirp_i) begin
      take_cause = CAUSE_TIRP;
    end else if (cmt_ecall_i) begin
      take_cause = CAUSE_ECALL;
    end else if (cmt_mret_i) begin
      take_mret = 1'b1;
    end
  end

  assign commit_target = mret_q ? mepc_i : (mtvec_i & TVEC_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      mret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && take) begin
        pc_q    <= cmt_pc_i;
        cause_q <= take_cause;
        mret_q  <= take_mret;
      end
      // Sampled in COMMIT so the target reflects CSR state after any
      // in-flight CSR writes drained.
      if (state_q == S_COMMIT) begin
        target_q <= commit_target;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    cmt_ready_o         = 1'b0;
    flush_o             = 1'b1;
    csr_exception_o     = 1'b0;
    csr_mret_o          = 1'b0;
    csr_mepc_hwdata_o   = '0;
    csr_mcause_hwdata_o = '0;
    redirect_valid_o    = 1'b0;
    redirect_pc_o       = '0;
    case (state_q)
      S_IDLE: begin
        cmt_ready_o = 1'b1;
        flush_o     = 1'b0;
        if (take) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lsu_idle_i) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (mret_q) begin
          csr_mret_o = 1'b1;
        end else begin
          csr_exception_o     = 1'b1;
          csr_mepc_hwdata_o   = pc_q;
          csr_mcause_hwdata_o = cause_q;
        end
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040729_trap_ctrl.sv
module tb_ysyx_22040729_trap_ctrl;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmt_valid_i;
  logic [W-1:0] cmt_pc_i;
  logic         cmt_ecall_i;
  logic         cmt_mret_i;
  logic         cmt_ready_o;
  logic         eirp_i;
  logic         tirp_i;
  logic [W-1:0] mtvec_i;
  logic [W-1:0] mepc_i;
  logic         lsu_idle_i;
  logic         csr_exception_o;
  logic         csr_mret_o;
  logic [W-1:0] csr_mepc_hwdata_o;
  logic [W-1:0] csr_mcause_hwdata_o;
  logic         flush_o;
  logic         redirect_valid_o;
  logic [W-1:0] redirect_pc_o;
  logic         redirect_ready_i;

  int checks = 0;
  int passes = 0;

  // observation record filled by observe()
  int           n_exc, n_mret, flush_cycles, first_rv, bad_hw;
  bit           rpc_unstable, timed_out;
  logic [W-1:0] mepc_seen, mcause_seen, rpc_seen;

  always #5 clk = ~clk;

  ysyx_22040729_trap_ctrl #(.DATA_WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmt_valid_i         (cmt_valid_i),
    .cmt_pc_i            (cmt_pc_i),
    .cmt_ecall_i         (cmt_ecall_i),
    .cmt_mret_i          (cmt_mret_i),
    .cmt_ready_o         (cmt_ready_o),
    .eirp_i              (eirp_i),
    .tirp_i              (tirp_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .lsu_idle_i          (lsu_idle_i),
    .csr_exception_o     (csr_exception_o),
    .csr_mret_o          (csr_mret_o),
    .csr_mepc_hwdata_o   (csr_mepc_hwdata_o),
    .csr_mcause_hwdata_o (csr_mcause_hwdata_o),
    .flush_o             (flush_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_pc_o       (redirect_pc_o),
    .redirect_ready_i    (redirect_ready_i)
  );

  task automatic clear_cmt();
    cmt_valid_i = 1'b0;
    cmt_ecall_i = 1'b0;
    cmt_mret_i  = 1'b0;
    eirp_i      = 1'b0;
    tirp_i      = 1'b0;
    cmt_pc_i    = '0;
  endtask

  // Called at a negedge with the take inputs already applied (cycle 0).
  // Runs until the DUT is back in IDLE, recording what it saw.
  // lsu_idle_i is low for cycles 0..lsu_low-1; redirect_ready_i is low for the
  // first rdy_low REDIRECT cycles. With hold=1 commit/interrupt inputs are kept
  // busy (with different values) while the controller is occupied.
  task automatic observe(input int lsu_low, input int rdy_low, input bit hold);
    int  cyc;
    int  rv_cnt;
    bit  done;
    n_exc = 0; n_mret = 0; flush_cycles = 0; first_rv = -1; bad_hw = 0;
    rpc_unstable = 1'b0; timed_out = 1'b0;
    mepc_seen = '0; mcause_seen = '0; rpc_seen = '0;
    cyc = 0; rv_cnt = 0; done = 1'b0;
    lsu_idle_i = (lsu_low == 0);
    redirect_ready_i = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        clear_cmt();
        if (hold) begin
          cmt_valid_i = 1'b1;
          eirp_i      = 1'b1;
          cmt_pc_i    = 64'hdead_beef_0000_0000;
        end
      end
      if (cmt_ready_o) begin
        done = 1'b1;
        clear_cmt();
        redirect_ready_i = 1'b0;
        lsu_idle_i = 1'b1;
      end else begin
        if (flush_o) flush_cycles++;
        if (csr_exception_o) begin
          n_exc++;
          mepc_seen   = csr_mepc_hwdata_o;
          mcause_seen = csr_mcause_hwdata_o;
        end else if (csr_mepc_hwdata_o !== '0 || csr_mcause_hwdata_o !== '0) begin
          bad_hw++;
        end
        if (csr_mret_o) n_mret++;
        if (redirect_valid_o) begin
          rv_cnt++;
          if (first_rv < 0) begin
            first_rv = cyc;
            rpc_seen = redirect_pc_o;
          end else if (redirect_pc_o !== rpc_seen) begin
            rpc_unstable = 1'b1;
          end
          redirect_ready_i = (rv_cnt > rdy_low);
        end
        lsu_idle_i = (cyc >= lsu_low);
        if (cyc >= 60) begin
          timed_out = 1'b1;
          done = 1'b1;
          $display("FAIL observe_timeout: still busy after %0d cycles, required return to IDLE", cyc);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          clear_cmt();
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_cmt();
    mtvec_i = 64'h8000_0101;
    mepc_i = '0;
    lsu_idle_i = 1'b1;
    redirect_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cmt_ready_o !== 1'b1 || flush_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      $display("FAIL reset_ctrl: ready=%b flush=%b rv=%b, required 1 0 0", cmt_ready_o, flush_o, redirect_valid_o);
    end else passes++;
    checks++;
    if (csr_exception_o !== 1'b0 || csr_mret_o !== 1'b0 || csr_mepc_hwdata_o !== '0 ||
        csr_mcause_hwdata_o !== '0 || redirect_pc_o !== '0) begin
      $display("FAIL reset_data: exc=%b mret=%b mepc=%h mcause=%h rpc=%h, required all 0",
               csr_exception_o, csr_mret_o, csr_mepc_hwdata_o, csr_mcause_hwdata_o, redirect_pc_o);
    end else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmt_ready_o !== 1'b1 || csr_exception_o !== 1'b0 || csr_mret_o !== 1'b0 || flush_o !== 1'b0) begin
      $display("FAIL post_reset_idle: ready=%b exc=%b mret=%b flush=%b, required 1 0 0 0",
               cmt_ready_o, csr_exception_o, csr_mret_o, flush_o);
    end else passes++;
  endtask

  task automatic test_no_take();
    eirp_i = 1'b1;
    tirp_i = 1'b1;
    observe(0, 0, 1'b0);
    checks++;
    if (flush_cycles !== 0 || n_exc !== 0) begin
      $display("FAIL no_take_irq_without_commit: flush=%0d exc=%0d, required 0 0", flush_cycles, n_exc);
    end else passes++;
    cmt_valid_i = 1'b1;
    cmt_pc_i = 64'h8000_0004;
    observe(0, 0, 1'b0);
    checks++;
    if (flush_cycles !== 0 || n_exc !== 0 || n_mret !== 0) begin
      $display("FAIL no_take_plain_commit: flush=%0d exc=%0d mret=%0d, required 0 0 0", flush_cycles, n_exc, n_mret);
    end else passes++;
  endtask

  task automatic test_ecall();
    cmt_valid_i = 1'b1;
    cmt_ecall_i = 1'b1;
    cmt_pc_i = 64'h8000_0010;
    observe(0, 0, 1'b0);
    checks++;
    if (n_exc !== 1 || n_mret !== 0 || timed_out) begin
      $display("FAIL ecall_strobes: exc=%0d mret=%0d timeout=%b, required 1 0 0", n_exc, n_mret, timed_out);
    end else passes++;
    checks++;
    if (mepc_seen !== 64'h8000_0010 || mcause_seen !== 64'd11) begin
      $display("FAIL ecall_csr: mepc=%h mcause=%h, required 80000010 b", mepc_seen, mcause_seen);
    end else passes++;
    checks++;
    if (rpc_seen !== 64'h8000_0100 || first_rv !== 3) begin
      $display("FAIL ecall_redirect: pc=%h at cycle %0d, required 80000100 at 3", rpc_seen, first_rv);
    end else passes++;
    checks++;
    if (flush_cycles !== 3 || bad_hw !== 0) begin
      $display("FAIL ecall_flush_hw: flush=%0d stray_hw=%0d, required 3 0", flush_cycles, bad_hw);
    end else passes++;
  endtask

  task automatic test_priority();
    cmt_valid_i = 1'b1;
    eirp_i = 1'b1;
    tirp_i = 1'b1;
    cmt_mret_i = 1'b1;
    cmt_pc_i = 64'h8000_0020;
    observe(0, 0, 1'b0);
    checks++;
    if (mcause_seen !== 64'h8000_0000_0000_000B || mepc_seen !== 64'h8000_0020) begin
      $display("FAIL prio_eirp: mcause=%h mepc=%h, required 800000000000000b 80000020", mcause_seen, mepc_seen);
    end else passes++;
    checks++;
    if (n_mret !== 0 || n_exc !== 1) begin
      $display("FAIL prio_strobes: exc=%0d mret=%0d, required 1 0", n_exc, n_mret);
    end else passes++;
    cmt_valid_i = 1'b1;
    tirp_i = 1'b1;
    cmt_ecall_i = 1'b1;
    cmt_pc_i = 64'h8000_0030;
    observe(0, 0, 1'b0);
    checks++;
    if (mcause_seen !== 64'h8000_0000_0000_0007 || mepc_seen !== 64'h8000_0030 || n_exc !== 1) begin
      $display("FAIL prio_tirp: mcause=%h mepc=%h exc=%0d, required 8000000000000007 80000030 1",
               mcause_seen, mepc_seen, n_exc);
    end else passes++;
  endtask

  task automatic test_mret();
    mepc_i = 64'h8000_0044;
    cmt_valid_i = 1'b1;
    cmt_mret_i = 1'b1;
    cmt_pc_i = 64'h8000_0200;
    observe(0, 0, 1'b0);
    checks++;
    if (n_mret !== 1 || n_exc !== 0 || bad_hw !== 0) begin
      $display("FAIL mret_strobes: mret=%0d exc=%0d stray_hw=%0d, required 1 0 0", n_mret, n_exc, bad_hw);
    end else passes++;
    checks++;
    if (rpc_seen !== 64'h8000_0044 || first_rv !== 3) begin
      $display("FAIL mret_redirect: pc=%h at cycle %0d, required 80000044 at 3", rpc_seen, first_rv);
    end else passes++;
  endtask

  task automatic test_stall();
    cmt_valid_i = 1'b1;
    cmt_ecall_i = 1'b1;
    cmt_pc_i = 64'h8000_0040;
    observe(5, 3, 1'b0);
    checks++;
    if (flush_cycles !== 10 || first_rv !== 7) begin
      $display("FAIL stall_timing: flush=%0d first_rv=%0d, required 10 7", flush_cycles, first_rv);
    end else passes++;
    checks++;
    if (rpc_unstable || rpc_seen !== 64'h8000_0100 || n_exc !== 1) begin
      $display("FAIL stall_redirect: unstable=%b pc=%h exc=%0d, required 0 80000100 1", rpc_unstable, rpc_seen, n_exc);
    end else passes++;
  endtask

  task automatic test_ignore_busy();
    cmt_valid_i = 1'b1;
    cmt_ecall_i = 1'b1;
    cmt_pc_i = 64'h8000_0050;
    observe(2, 1, 1'b1);
    checks++;
    if (n_exc !== 1 || mcause_seen !== 64'd11 || mepc_seen !== 64'h8000_0050) begin
      $display("FAIL busy_ignored: exc=%0d mcause=%h mepc=%h, required 1 b 80000050", n_exc, mcause_seen, mepc_seen);
    end else passes++;
    @(negedge clk);
    checks++;
    if (cmt_ready_o !== 1'b1 || flush_o !== 1'b0) begin
      $display("FAIL busy_no_retake: ready=%b flush=%b, required 1 0", cmt_ready_o, flush_o);
    end else passes++;
  endtask

  task automatic test_back_to_back();
    cmt_valid_i = 1'b1;
    cmt_ecall_i = 1'b1;
    cmt_pc_i = 64'h8000_0060;
    observe(0, 0, 1'b0);
    mepc_i = 64'h8000_0070;
    cmt_valid_i = 1'b1;
    cmt_mret_i = 1'b1;
    cmt_pc_i = 64'h8000_0300;
    observe(0, 0, 1'b0);
    checks++;
    if (n_mret !== 1 || n_exc !== 0 || rpc_seen !== 64'h8000_0070 || first_rv !== 3) begin
      $display("FAIL b2b_mret: mret=%0d exc=%0d pc=%h rv_cycle=%0d, required 1 0 80000070 3",
               n_mret, n_exc, rpc_seen, first_rv);
    end else passes++;
  endtask

  task automatic test_reset_mid();
    int strobes;
    int not_ready;
    cmt_valid_i = 1'b1;
    cmt_ecall_i = 1'b1;
    cmt_pc_i = 64'h8000_0080;
    lsu_idle_i = 1'b0;
    @(negedge clk);
    clear_cmt();
    checks++;
    if (flush_o !== 1'b1 || cmt_ready_o !== 1'b0) begin
      $display("FAIL mid_in_drain: flush=%b ready=%b, required 1 0", flush_o, cmt_ready_o);
    end else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (cmt_ready_o !== 1'b1 || flush_o !== 1'b0 || csr_exception_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      $display("FAIL mid_reset_async: ready=%b flush=%b exc=%b rv=%b, required 1 0 0 0",
               cmt_ready_o, flush_o, csr_exception_o, redirect_valid_o);
    end else passes++;
    @(negedge clk);
    rst = 1'b0;
    lsu_idle_i = 1'b1;
    strobes = 0;
    not_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (csr_exception_o || csr_mret_o || redirect_valid_o) strobes++;
      if (!cmt_ready_o) not_ready++;
    end
    checks++;
    if (strobes !== 0 || not_ready !== 0) begin
      $display("FAIL mid_reset_after: strobe_cycles=%0d busy_cycles=%0d, required 0 0", strobes, not_ready);
    end else passes++;
  endtask

  initial begin
    test_reset();
    test_no_take();
    test_ecall();
    test_priority();
    test_mret();
    test_stall();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040729_trap_ctrl.md
YSYX_22040729_TRAP_CTRL -- requirements
Module: ysyx_22040729_trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of PC, CSR data and cause paths.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmt_valid_i  input  1  an instruction is at commit this cycle.
REQ-005 SHALL have port cmt_pc_i  input  DATA_WIDTH  PC of the committing instruction.
REQ-006 SHALL have port cmt_ecall_i / cmt_mret_i  input  1 each  committing instruction is ecall / mret.
REQ-007 SHALL have port cmt_ready_o  output  1  controller accepts commit; low while busy.
REQ-008 SHALL have port eirp_i / tirp_i  input  1 each  gated external / timer interrupt from the CSR file.
REQ-009 SHALL have port mtvec_i / mepc_i  input  DATA_WIDTH  current CSR mtvec / mepc.
REQ-010 SHALL have port lsu_idle_i  input  1  no outstanding memory transaction.
REQ-011 SHALL have ports csr_exception_o, csr_mret_o  output  1  one-cycle hardware-update strobes to the CSR file.
REQ-012 SHALL have ports csr_mepc_hwdata_o, csr_mcause_hwdata_o  output  DATA_WIDTH  trap values to the CSR file.
REQ-013 SHALL have port flush_o  output  1  kill younger pipeline stages.
REQ-014 SHALL have ports redirect_valid_o  output  1, redirect_pc_o  output  DATA_WIDTH, redirect_ready_i  input  1  fetch redirect handshake.

Function
REQ-015 SHALL implement FSM states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-016 In IDLE, cmt_ready_o SHALL be 1; all other outputs SHALL be 0.
REQ-017 A trap SHALL be taken in IDLE when cmt_valid_i and (eirp_i | tirp_i | cmt_ecall_i | cmt_mret_i); next state DRAIN.
REQ-018 Priority SHALL be eirp > tirp > ecall > mret; a lower event in the same cycle is dropped (instruction not retired, replayed later).
REQ-019 On take, SHALL latch pc = cmt_pc_i, kind (trap/mret), cause: eirp {1,0..,11}, tirp {1,0..,7}, ecall 11 (MSB 0).
REQ-020 flush_o SHALL be 1 and cmt_ready_o 0 in every state other than IDLE.
REQ-021 DRAIN SHALL hold until lsu_idle_i=1, then go to COMMIT (minimum one cycle in DRAIN).
REQ-022 COMMIT SHALL last exactly one cycle: for trap, csr_exception_o=1, csr_mepc_hwdata_o=latched pc, csr_mcause_hwdata_o=latched cause; for mret, csr_mret_o=1; never both.
REQ-023 In COMMIT the target SHALL be latched: trap -> {mtvec_i[W-1:2],2'b00}; mret -> mepc_i; next state REDIRECT.
REQ-024 REDIRECT SHALL drive redirect_valid_o=1 with stable redirect_pc_o until redirect_ready_i=1 in the same cycle, then IDLE.
REQ-025 Interrupt or commit inputs outside IDLE SHALL be ignored (level interrupts re-evaluated on return to IDLE).
REQ-026 csr_*_hwdata_o SHALL be 0 outside COMMIT.
REQ-027 Latency take->redirect_valid_o SHALL be 3 cycles when lsu_idle_i stays 1.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, clear latched pc/cause/target to 0, drive cmt_ready_o=1 and all other outputs 0, including mid-operation.
REQ-029 No strobe SHALL be emitted on the first cycle after reset release unless a take occurs per REQ-017 two edges later.

Verification
REQ-030 ecall at pc 0x80000010, mtvec 0x80000101, lsu idle -> one csr_exception_o pulse, mepc 0x80000010, mcause 11, redirect_pc 0x80000100.
REQ-031 eirp_i, tirp_i and cmt_mret_i together at pc 0x80000020 -> mcause 0x800000000000000B, no csr_mret_o.
REQ-032 mret with mepc_i 0x80000044 -> csr_mret_o pulse, no csr_exception_o, redirect_pc 0x80000044.
REQ-033 lsu_idle_i low 5 cycles and redirect_ready_i low 3 cycles -> flush_o held 5+1+4 cycles, redirect_pc stable throughout.
REQ-034 rst asserted during DRAIN -> all outputs 0 and cmt_ready_o 1 before next edge, no strobe afterwards.
